// File: rtl/alu_flag_stage_pkg.sv
// Shared constants for the ALU flag stage.
//   FIFO_DEPTH        : entries held between the adder and downstream
//   FLAG_N/Z/V        : bit positions inside the packed flag register
//   SAT_POS / SAT_NEG : saturation values at the default 16-bit width; the
//                       top scales them to WIDTH (MSB pattern + fill bit)
package alu_flag_stage_pkg;

  localparam int unsigned FIFO_DEPTH    = 2;
  localparam int unsigned DEFAULT_WIDTH = 16;

  localparam int unsigned NUM_FLAGS = 3;
  localparam int unsigned FLAG_N    = 0;
  localparam int unsigned FLAG_Z    = 1;
  localparam int unsigned FLAG_V    = 2;

  localparam logic [DEFAULT_WIDTH-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DEFAULT_WIDTH-1:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/alu_flag_stage_skid_fifo2.sv
// Two-entry FIFO buffering final ALU results.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : write request (ignored when full or flushing)
//   pop_i      : read request (ignored when empty)
//   flush_i    : synchronous discard of all entries
//   wdata_i    : value to store
//   ready_o    : space available, from registered count only
//   valid_o    : head entry present
//   rdata_o    : head entry
module skid_fifo2
  import alu_flag_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam logic [1:0] DEPTH_CNT = 2'(FIFO_DEPTH);

  logic [1:0]       count_q, count_d;
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push_i & (count_q < DEPTH_CNT);
  assign do_pop  = pop_i & (count_q != '0);

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush_i) begin
      count_d = '0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (do_push) wptr_d = ~wptr_q;
      if (do_pop)  rptr_d = ~rptr_q;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage is cleared on reset so the head reads zero while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign ready_o = count_q < DEPTH_CNT;
  assign valid_o = count_q != '0;
  assign rdata_o = mem_q[rptr_q];

endmodule

// File: rtl/alu_flag_stage.sv
// ALU result stage: optional saturation, N/Z/V flag register and a 2-entry
// output buffer.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : upstream handshake
//   sum, ovfl, a_msb      : raw adder sum, signed overflow, sign of operand A
//   sat_en                : saturate on overflow
//   upd_n, upd_z, upd_v   : per-flag write enables
//   flush                 : discard buffered entries
//   out_valid / out_ready : downstream handshake
//   result                : head entry (final value)
//   flag_n, flag_z, flag_v: architectural flags
module alu_flag_stage
  import alu_flag_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             ovfl,
  input  logic             a_msb,
  input  logic             sat_en,
  input  logic             upd_n,
  input  logic             upd_z,
  input  logic             upd_v,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  // Scale the 16-bit constants to WIDTH: keep the MSB, replicate the bit below.
  localparam logic [WIDTH-1:0] SAT_POS_W =
    {SAT_POS[DEFAULT_WIDTH-1], {(WIDTH-1){SAT_POS[DEFAULT_WIDTH-2]}}};
  localparam logic [WIDTH-1:0] SAT_NEG_W =
    {SAT_NEG[DEFAULT_WIDTH-1], {(WIDTH-1){SAT_NEG[DEFAULT_WIDTH-2]}}};

  logic                 accept;
  logic                 pop;
  logic [WIDTH-1:0]     final_val;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    final_val = sum;
    if (sat_en && ovfl) final_val = a_msb ? SAT_NEG_W : SAT_POS_W;
  end

  // Flags follow the accept even when the same-cycle flush drops the entry.
  always_comb begin
    flags_d = flags_q;
    if (accept) begin
      if (upd_n) flags_d[FLAG_N] = final_val[WIDTH-1];
      if (upd_z) flags_d[FLAG_Z] = (final_val == '0);
      if (upd_v) flags_d[FLAG_V] = ovfl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  skid_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (accept),
    .pop_i  (pop),
    .flush_i(flush),
    .wdata_i(final_val),
    .ready_o(in_ready),
    .valid_o(out_valid),
    .rdata_o(result)
  );

  assign flag_n = flags_q[FLAG_N];
  assign flag_z = flags_q[FLAG_Z];
  assign flag_v = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_flag_stage.sv
module tb_alu_flag_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum;
  logic        ovfl;
  logic        a_msb;
  logic        sat_en;
  logic        upd_n;
  logic        upd_z;
  logic        upd_v;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_flag_stage #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .ovfl     (ovfl),
    .a_msb    (a_msb),
    .sat_en   (sat_en),
    .upd_n    (upd_n),
    .upd_z    (upd_z),
    .upd_v    (upd_v),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .flag_v   (flag_v)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] s, input logic o,
                        input logic am, input logic se, input logic [2:0] upd_nzv);
    in_valid = v; sum = s; ovfl = o; a_msb = am; sat_en = se;
    {upd_n, upd_z, upd_v} = upd_nzv;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b000);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {flag_n, flag_z, flag_v}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    out_ready = 1'b0;
    set_in(1'b1, 16'h7FFE, 1'b0, 1'b0, 1'b1, 3'b111);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pass_valid got=%0b exp=1", out_valid); end
    checks++; if (result !== 16'h7FFE) begin failures++; $display("FAIL pass_result got=%h exp=7ffe", result); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b000) begin failures++; $display("FAIL pass_flags got=%b exp=000", {flag_n, flag_z, flag_v}); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pass_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    set_in(1'b1, 16'h8001, 1'b1, 1'b0, 1'b1, 3'b111);
    tick();
    checks++; if (result !== 16'h7FFF) begin failures++; $display("FAIL sat_pos_result got=%h exp=7fff", result); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b001) begin failures++; $display("FAIL sat_pos_flags got=%b exp=001", {flag_n, flag_z, flag_v}); end
    sat_en = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || result !== 16'h8001) begin failures++; $display("FAIL nosat_result got=%h/%0b exp=8001/1", result, out_valid); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b101) begin failures++; $display("FAIL nosat_flags got=%b exp=101", {flag_n, flag_z, flag_v}); end
    set_in(1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1, 3'b111);
    tick();
    checks++; if (result !== 16'h8000) begin failures++; $display("FAIL sat_neg_result got=%h exp=8000", result); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b101) begin failures++; $display("FAIL sat_neg_flags got=%b exp=101", {flag_n, flag_z, flag_v}); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_zero_flag();
    out_ready = 1'b1;
    set_in(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b010);
    tick();
    in_valid = 1'b0;
    checks++; if (result !== 16'h0000 || out_valid !== 1'b1) begin failures++; $display("FAIL zero_result got=%h/%0b exp=0000/1", result, out_valid); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b111) begin failures++; $display("FAIL zero_flags got=%b exp=111", {flag_n, flag_z, flag_v}); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_in(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 3'b111);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%0b exp=1", in_ready); end
    tick();
    sum = 16'h0002;
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%0b exp=0", in_ready); end
    checks++; if (result !== 16'h0001) begin failures++; $display("FAIL b2b_head1 got=%h exp=0001", result); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b000) begin failures++; $display("FAIL b2b_flags2 got=%b exp=000", {flag_n, flag_z, flag_v}); end
    sum = 16'h0003; ovfl = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b0 || result !== 16'h0001) begin failures++; $display("FAIL b2b_stall got=%0b/%h exp=0/0001", in_ready, result); end
    checks++; if (flag_v !== 1'b0) begin failures++; $display("FAIL b2b_no_accept_v got=%0b exp=0", flag_v); end
    out_ready = 1'b1;
    tick();
    checks++; if (result !== 16'h0002 || in_ready !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_head2 got=%h/%0b/%0b exp=0002/1/1", result, in_ready, out_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (result !== 16'h0003 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_head3 got=%h/%0b exp=0003/1", result, out_valid); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b001) begin failures++; $display("FAIL b2b_flags3 got=%b exp=001", {flag_n, flag_z, flag_v}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_in(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 3'b111);
    tick();
    sum = 16'h0020;
    tick();
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL flush_fill got=%0b/%0b exp=1/0", out_valid, in_ready); end
    flush = 1'b1; out_ready = 1'b1;
    set_in(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3'b100);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_empty got=%0b/%0b exp=0/1", out_valid, in_ready); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b000) begin failures++; $display("FAIL flush_flags got=%b exp=000", {flag_n, flag_z, flag_v}); end
    flush = 1'b1;
    set_in(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 3'b100);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%0b exp=0", out_valid); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b100) begin failures++; $display("FAIL flush_accept_flags got=%b exp=100", {flag_n, flag_z, flag_v}); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_in(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0, 3'b111);
    tick();
    sum = 16'h0066;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || flag_v !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0b/%0b exp=1/1", out_valid, flag_v); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rmid_hs got=%0b/%0b exp=0/1", out_valid, in_ready); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b000) begin failures++; $display("FAIL rmid_flags got=%b exp=000", {flag_n, flag_z, flag_v}); end
    checks++; if (result !== 16'h0000) begin failures++; $display("FAIL rmid_result got=%h exp=0000", result); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_after got=%0b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_saturate();
    test_zero_flag();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_flag_stage.md
ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

Interface
- REQ-001: Parameter WIDTH, default 16, datapath width of sum and result.
- REQ-002: clk  input  1  single clock; all state updates on the rising edge.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: in_valid  input  1  upstream adder result is present.
- REQ-005: in_ready  output  1  stage accepts an entry this cycle.
- REQ-006: sum  input  WIDTH  raw adder sum.
- REQ-007: ovfl  input  1  adder signed-overflow indication.
- REQ-008: a_msb  input  1  sign bit of operand A; selects the saturation direction.
- REQ-009: sat_en  input  1  saturate this result on overflow.
- REQ-010: upd_n, upd_z, upd_v  input  1 each  per-flag write enables for this result.
- REQ-011: flush  input  1  synchronous discard of all buffered entries.
- REQ-012: out_valid  output  1  head entry is valid.
- REQ-013: out_ready  input  1  downstream accepts the head entry.
- REQ-014: result  output  WIDTH  head entry's final (possibly saturated) value.
- REQ-015: flag_n, flag_z, flag_v  output  1 each  architectural flag register.

Function
- REQ-016: Accept = in_valid & in_ready; pop = out_valid & out_ready.
- REQ-017: Final value = sat_en & ovfl ? (a_msb ? 0x8000 : 0x7FFF) : sum; constants are scaled to WIDTH as MSB-only and all-ones-but-MSB.
- REQ-018: Final value is computed combinationally before storage; storage holds final values only.
- REQ-019: Buffer is a 2-entry FIFO; in_ready = (count < 2), driven from registered count only, with no combinational path from out_ready.
- REQ-020: out_valid = (count > 0); result = head entry; latency from accept to out_valid is 1 cycle when the buffer is empty.
- REQ-021: Push and pop in the same cycle leave count unchanged and preserve order; push is impossible at count = 2.
- REQ-022: Pop at count = 0 is a no-op.
- REQ-023: Flags update on accept, in program order, independent of downstream stall.
- REQ-024: On accept, flags update as follows: N <= final[WIDTH-1] if upd_n; Z <= (final == 0) if upd_z; V <= ovfl if upd_v. Disabled flags hold.
- REQ-025: Flush clears count and pointers next edge. A same-cycle accept is dropped, but its flag update still occurs; flags are otherwise unchanged by flush.
- REQ-026: Write and read pointers are 1 bit each and wrap modulo 2.

Reset
- REQ-027: While rst is high, count=0, pointers=0, out_valid=0, in_ready=1, flag_n=flag_z=flag_v=0, and result=0.
- REQ-028: Reset mid-operation discards buffered entries immediately; no pop or flag update occurs on that edge.

Structure
- REQ-029: Shared package holds the saturation constants SAT_POS and SAT_NEG, the flag index constants FLAG_N, FLAG_Z and FLAG_V, and the FIFO depth constant (2).
- REQ-030: The 2-entry FIFO is a sub-module named skid_fifo2, parameterised by WIDTH.
- REQ-031: Saturation and flag logic remain in alu_flag_stage; no latches, and one always-block style per state element.

Verification
- REQ-032: Reset asserted mid-stream with 2 entries held -> out_valid=0, in_ready=1, flags 000 while rst is high.
- REQ-033: sum=0x7FFE, ovfl=0, sat_en=1, all upd=1 -> result=0x7FFE one cycle later, N=0 Z=0 V=0.
- REQ-034: sum=0x8001, ovfl=1, a_msb=0, sat_en=1 -> result=0x7FFF, V=1, N=0. Repeat with sat_en=0 -> result=0x8001, N=1.
- REQ-035: sum=0x0000, ovfl=0, upd_z=1 only, with prior N=1 -> Z=1, N stays 1.
- REQ-036: out_ready=0, push 0x0001, 0x0002, 0x0003 -> in_ready drops after 2 accepts. Then out_ready=1 -> results 0x0001 then 0x0002, then 0x0003 is accepted, order preserved. Flags reflect 0x0003 at its accept.
- REQ-037: Count=2 with flush and out_ready=1 in the same cycle -> count=0 next cycle, out_valid=0, flags unchanged.
